spk_out_fifo: RTL and testbench

Spike output buffer downstream of the node work controller and soma. Each cycle it captures the neuron coordinate `{z,y,x}` from the work controller when the soma reports a fire. It queues the spike in a FIFO and presents it to the router over a valid/ready handshake. It raises a registered almost-full flag that the work controller uses to pause its neuron sweep.

---
 rtl/spk_out_fifo_pkg.sv | 16 +
 rtl/sync_fifo_mem.sv | 24 ++
 rtl/spk_out_fifo.sv | 88 ++++++++
 tb/tb_spk_out_fifo.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/spk_out_fifo_pkg.sv
// Shared spike-word definitions used by the work controller, the spike output
// buffer and the router interface.
package spk_out_fifo_pkg;
    localparam int SPK_SW        = 24;
    localparam int SPK_FW        = SPK_SW / 3;
    localparam int SPK_DEPTH     = 16;
    localparam int SPK_AF_MARGIN = 4;
    localparam int SPK_CW        = 16;

    // Neuron coordinate as carried on spk_neuid / out_data.
    typedef struct packed {
        logic [SPK_FW-1:0] z;
        logic [SPK_FW-1:0] y;
        logic [SPK_FW-1:0] x;
    } spk_coord_t;
endpackage

// File: rtl/sync_fifo_mem.sv
// Register-array storage for the spike FIFO: one synchronous write port and
// one asynchronous read port, so the head word falls through without latency.
module sync_fifo_mem #(
    parameter int SW    = 24,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [SW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [SW-1:0] rd_data
);
    logic [SW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];
endmodule

// File: rtl/spk_out_fifo.sv
// Spike output buffer: queues fired neuron coordinates for the router and
// raises a registered almost-full flag that pauses the neuron sweep.
module spk_out_fifo
    import spk_out_fifo_pkg::*;
#(
    parameter int SW        = SPK_SW,
    parameter int DEPTH     = SPK_DEPTH,
    parameter int AW        = 4,
    parameter int AF_MARGIN = SPK_AF_MARGIN,
    parameter int CW        = SPK_CW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          spk_vld,
    input  logic [SW-1:0] spk_neuid,
    output logic          spk_out_config_full,
    output logic          out_vld,
    output logic [SW-1:0] out_data,
    input  logic          out_rdy,
    output logic          busy,
    output logic [CW-1:0] drop_cnt,
    input  logic          drop_clr
);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_LVL   = (AW+1)'(DEPTH - AF_MARGIN);
    localparam logic [CW-1:0] DROP_MAX = {CW{1'b1}};

    // Handshake: a word moves to the router on any cycle with out_vld && out_rdy;
    // out_vld never depends on out_rdy and out_data holds while stalled.
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_next;
    logic          pop;
    logic          push_acc;
    logic          drop;

    assign out_vld  = (count != '0);
    assign busy     = out_vld;
    assign pop      = out_vld & out_rdy;
    // A full buffer still takes a spike when the head leaves in the same cycle.
    assign push_acc = spk_vld & ((count != FULL_LVL) | pop);
    assign drop     = spk_vld & ~push_acc;

    assign count_next = count + (AW+1)'(push_acc) - (AW+1)'(pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr              <= '0;
            rd_ptr              <= '0;
            count               <= '0;
            spk_out_config_full <= 1'b0;
        end else begin
            if (push_acc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count               <= count_next;
            spk_out_config_full <= (count_next >= AF_LVL);
        end
    end

    // Clear wins over a same-cycle drop, which is then not counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (drop_clr) begin
            drop_cnt <= '0;
        end else if (drop && (drop_cnt != DROP_MAX)) begin
            drop_cnt <= drop_cnt + CW'(1);
        end
    end

    sync_fifo_mem #(
        .SW    (SW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push_acc),
        .wr_addr (wr_ptr),
        .wr_data (spk_neuid),
        .rd_addr (rd_ptr),
        .rd_data (out_data)
    );
endmodule

// File: tb/tb_spk_out_fifo.sv
// Bench for spk_out_fifo: reset, a directed vector table, corner-case sequences
// and randomized traffic compared against a queue-based model of the buffer.
module tb_spk_out_fifo;
    import spk_out_fifo_pkg::*;

    localparam int SW        = 24;
    localparam int DEPTH     = 16;
    localparam int AW        = 4;
    localparam int AF_MARGIN = 4;
    localparam int CW        = 16;
    localparam int DROP_SAT  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          spk_vld;
    logic [SW-1:0] spk_neuid;
    logic          full;
    logic          out_vld;
    logic [SW-1:0] out_data;
    logic          out_rdy;
    logic          busy;
    logic [CW-1:0] drop_cnt;
    logic          drop_clr;

    always #5 clk = ~clk;

    spk_out_fifo #(
        .SW        (SW),
        .DEPTH     (DEPTH),
        .AW        (AW),
        .AF_MARGIN (AF_MARGIN),
        .CW        (CW)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .spk_vld             (spk_vld),
        .spk_neuid           (spk_neuid),
        .spk_out_config_full (full),
        .out_vld             (out_vld),
        .out_data            (out_data),
        .out_rdy             (out_rdy),
        .busy                (busy),
        .drop_cnt            (drop_cnt),
        .drop_clr            (drop_clr)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the buffer contents as an ordered queue plus a drop tally.
    logic [SW-1:0] exp_q[$];
    int            model_drops = 0;

    typedef struct {
        bit            vld;
        logic [SW-1:0] id;
        bit            rdy;
        bit            clr;
        bit            e_vld;
        bit            chk_data;
        logic [SW-1:0] e_data;
        bit            e_full;
        logic [CW-1:0] e_drop;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit v, input logic [SW-1:0] id, input bit r, input bit c);
        bit do_pop;
        bit do_acc;
        do_pop = r && (exp_q.size() != 0);
        do_acc = v && ((exp_q.size() < DEPTH) || do_pop);
        if (do_pop) void'(exp_q.pop_front());
        if (do_acc) exp_q.push_back(id);
        if (c) model_drops = 0;
        else if (v && !do_acc && model_drops < DROP_SAT) model_drops++;
    endtask

    task automatic check_model();
        chk("out_vld", out_vld, exp_q.size() != 0);
        chk("busy", busy, exp_q.size() != 0);
        chk("full", full, exp_q.size() >= DEPTH - AF_MARGIN);
        chk("drop_cnt", drop_cnt, model_drops);
        if (exp_q.size() != 0) chk("out_data", out_data, exp_q[0]);
    endtask

    task automatic apply(input bit v, input logic [SW-1:0] id, input bit r, input bit c);
        spk_vld   = v;
        spk_neuid = id;
        out_rdy   = r;
        drop_clr  = c;
        model_step(v, id, r, c);
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic drain();
        while (exp_q.size() != 0) apply(1'b0, '0, 1'b1, 1'b0);
    endtask

    initial begin
        spk_coord_t c0;
        logic [SW-1:0] w;
        int rdy_pct;

        c0 = '{z: 8'h03, y: 8'h02, x: 8'h01};
        tbl[0] = '{1, c0,          1, 0, 1, 1, 24'h030201, 0, 0};
        tbl[1] = '{0, 24'h0,       1, 0, 0, 0, 24'h0,      0, 0};
        tbl[2] = '{1, 24'h0A0B0C,  0, 0, 1, 1, 24'h0A0B0C, 0, 0};
        tbl[3] = '{1, 24'h111111,  0, 0, 1, 1, 24'h0A0B0C, 0, 0};
        tbl[4] = '{0, 24'h0,       1, 0, 1, 1, 24'h111111, 0, 0};
        tbl[5] = '{0, 24'h0,       1, 0, 0, 0, 24'h0,      0, 0};

        // Reset held with a fire strobe active.
        rst_n = 1'b0; spk_vld = 1'b1; spk_neuid = 24'hFFFFFF; out_rdy = 1'b0; drop_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_vld", out_vld, 0);
        chk("rst_busy", busy, 0);
        chk("rst_full", full, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        spk_vld = 1'b0;
        rst_n   = 1'b1;
        for (int i = 0; i < 10; i++) begin
            apply(1'b0, '0, 1'b1, 1'b0);
            chk("post_rst_idle", out_vld, 0);
        end

        // Directed vectors: single spike with latency, hold under stall, FIFO order.
        for (int i = 0; i < 6; i++) begin
            apply(tbl[i].vld, tbl[i].id, tbl[i].rdy, tbl[i].clr);
            chk($sformatf("vec%0d_vld", i), out_vld, tbl[i].e_vld);
            if (tbl[i].chk_data) chk($sformatf("vec%0d_data", i), out_data, tbl[i].e_data);
            chk($sformatf("vec%0d_full", i), full, tbl[i].e_full);
            chk($sformatf("vec%0d_drop", i), drop_cnt, tbl[i].e_drop);
        end

        // Almost-full threshold at DEPTH-AF_MARGIN entries, then release after one pop.
        for (int i = 1; i <= 12; i++) begin
            apply(1'b1, SW'(32'h200 + i), 1'b0, 1'b0);
            chk($sformatf("af_push%0d", i), full, i >= 12);
        end
        apply(1'b0, '0, 1'b1, 1'b0);
        chk("af_release", full, 0);
        drain();

        // Overflow after a pointer pre-offset of five entries.
        for (int i = 0; i < 5; i++) apply(1'b1, SW'(32'h300 + i), 1'b0, 1'b0);
        drain();
        apply(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) apply(1'b1, SW'(32'h100 + i), 1'b0, 1'b0);
        chk("ovf_drop_cnt", drop_cnt, 4);
        chk("ovf_full", full, 1);
        // Full buffer with simultaneous push and pop: nothing dropped.
        apply(1'b1, 24'hABCDEF, 1'b1, 1'b0);
        chk("full_pushpop_drop", drop_cnt, 4);
        for (int i = 0; i < 16; i++) begin
            w = (i < 15) ? SW'(32'h101 + i) : 24'hABCDEF;
            chk($sformatf("drain%0d_vld", i), out_vld, 1);
            chk($sformatf("drain%0d_data", i), out_data, w);
            apply(1'b0, '0, 1'b1, 1'b0);
        end
        chk("drain_empty", out_vld, 0);

        // Drop counter saturation and clear priority.
        apply(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH; i++) apply(1'b1, SW'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < (1 << CW) + 3; i++) apply(1'b1, SW'($urandom), 1'b0, 1'b0);
        chk("sat_drop_cnt", drop_cnt, 16'hFFFF);
        apply(1'b1, SW'($urandom), 1'b0, 1'b1);
        chk("clr_with_drop", drop_cnt, 0);
        apply(1'b1, SW'($urandom), 1'b0, 1'b0);
        chk("drop_after_clr", drop_cnt, 1);
        drain();

        // Randomized traffic in phases of differing router readiness.
        for (int p = 0; p < 4; p++) begin
            rdy_pct = (p == 0) ? 20 : (p == 2) ? 85 : 50;
            for (int i = 0; i < 600; i++) begin
                apply($urandom_range(0, 99) < 60, SW'($urandom),
                      $urandom_range(0, 99) < rdy_pct, $urandom_range(0, 199) == 0);
            end
        end

        // Reset mid-operation discards the queued spikes at once.
        for (int i = 0; i < 5; i++) apply(1'b1, SW'(32'h400 + i), 1'b0, 1'b0);
        rst_n = 1'b0;
        #2;
        chk("async_rst_vld", out_vld, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_full", full, 0);
        exp_q.delete();
        model_drops = 0;
        spk_vld = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            apply(1'b0, '0, 1'b1, 1'b0);
            chk("post_midrst_idle", out_vld, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
